// File: rtl/calc_pkg.sv
// Shared definitions for the multi-digit calculator: PS/2 set-2 make codes,
// FSM states, operator encoding and the scan-code-to-digit decoder.
package calc_pkg;

    localparam logic [7:0] SC_0        = 8'h45;
    localparam logic [7:0] SC_1        = 8'h16;
    localparam logic [7:0] SC_2        = 8'h1E;
    localparam logic [7:0] SC_3        = 8'h26;
    localparam logic [7:0] SC_4        = 8'h25;
    localparam logic [7:0] SC_5        = 8'h2E;
    localparam logic [7:0] SC_6        = 8'h36;
    localparam logic [7:0] SC_7        = 8'h3D;
    localparam logic [7:0] SC_8        = 8'h3E;
    localparam logic [7:0] SC_9        = 8'h46;
    localparam logic [7:0] SC_PLUS     = 8'h79;
    localparam logic [7:0] SC_MINUS_KP = 8'h7B;
    localparam logic [7:0] SC_MINUS    = 8'h4E;
    localparam logic [7:0] SC_MUL      = 8'h7C;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_ESC      = 8'h76;

    typedef enum logic [2:0] {
        ST_OPA,
        ST_OPB,
        ST_CALC,
        ST_CONV,
        ST_SHOW,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_e;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] digit;
    } digit_dec_t;

    function automatic digit_dec_t decode_digit(input logic [7:0] code);
        digit_dec_t r;
        r.is_digit = 1'b1;
        r.digit    = 4'd0;
        case (code)
            SC_0: r.digit = 4'd0;
            SC_1: r.digit = 4'd1;
            SC_2: r.digit = 4'd2;
            SC_3: r.digit = 4'd3;
            SC_4: r.digit = 4'd4;
            SC_5: r.digit = 4'd5;
            SC_6: r.digit = 4'd6;
            SC_7: r.digit = 4'd7;
            SC_8: r.digit = 4'd8;
            SC_9: r.digit = 4'd9;
            default: r.is_digit = 1'b0;
        endcase
        return r;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/calc_seq_engine_bin2bcd.sv
// Sequential double-dabble: one shift/add-3 step per cycle. done is high in the
// cycle of the last step; bcd holds the finished digits from the next cycle on.
module bin2bcd_seq #(
    parameter int W  = 17,
    parameter int ND = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [W-1:0]    bin,
    output logic            done,
    output logic [4*ND-1:0] bcd
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]    sh_q;
    logic [4*ND-1:0] bcd_q;
    logic [4*ND-1:0] bcd_d;
    logic [CW-1:0]   cnt_q;

    // Adjust each nibble, then shift the whole chain left by one, feeding
    // the next binary bit into the LSD.
    always_comb begin : dd_step
        logic [3:0] nib;
        logic       carry;
        carry = sh_q[W-1];
        bcd_d = '0;
        for (int i = 0; i < ND; i++) begin
            nib = bcd_q[4*i +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_d[4*i +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || abort) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            sh_q  <= bin;
            bcd_q <= '0;
            cnt_q <= CW'(W);
        end else if (cnt_q != '0) begin
            sh_q  <= {sh_q[W-2:0], 1'b0};
            bcd_q <= bcd_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done = (cnt_q == CW'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/calc_seq_engine.sv
// Multi-digit keyboard calculator: two decimal operands, +/- (and * when
// CALC_MUL_EN is defined), signed result converted to BCD for the 7-seg display.
module calc_seq_engine
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OPW    = 14,
    parameter int RW     = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [7:0]              key_code,
    output logic [4*(DIGITS+1)-1:0] bcd_out,
    output logic                    sign,
    output logic                    busy,
    output logic                    result_valid,
    output logic                    overflow
);
    localparam int EW = 4 * DIGITS;
    localparam int BW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(DIGITS + 1);

    state_e         state_q, state_d;
    op_e            op_q;
    logic [OPW-1:0] a_q, b_q;
    logic [CW-1:0]  cnt_q;
    logic [EW-1:0]  entry_q;
    logic           sign_q;

    digit_dec_t     dec;
    logic           k_digit, k_op, k_enter, k_esc;
    op_e            k_opv;

    logic           acc_digit, take_op, restart, clear_all, conv_start;
    logic [RW-1:0]  mag;
    logic           mag_neg, calc_ovf;
    logic           conv_done;
    logic [BW-1:0]  conv_bcd;

    assign dec     = decode_digit(key_code);
    assign k_digit = key_valid && dec.is_digit;
    assign k_enter = key_valid && (key_code == SC_ENTER);
    assign k_esc   = key_valid && (key_code == SC_ESC);

    always_comb begin
        k_op  = 1'b0;
        k_opv = OP_ADD;
        if (key_valid) begin
            case (key_code)
                SC_PLUS: k_op = 1'b1;
                SC_MINUS, SC_MINUS_KP: begin
                    k_op  = 1'b1;
                    k_opv = OP_SUB;
                end
`ifdef CALC_MUL_EN
                SC_MUL: begin
                    k_op  = 1'b1;
                    k_opv = OP_MUL;
                end
`endif
                default: ;
            endcase
        end
    end

    // Result magnitude and sign, evaluated from the latched operands in CALC.
`ifdef CALC_MUL_EN
    localparam logic [2*OPW-1:0] PROD_MAX = (2*OPW)'(pow10(DIGITS + 1) - 1);
    logic [2*OPW-1:0] prod;
    assign prod = {{OPW{1'b0}}, a_q} * {{OPW{1'b0}}, b_q};
`endif

    always_comb begin
        mag      = '0;
        mag_neg  = 1'b0;
        calc_ovf = 1'b0;
        case (op_q)
            OP_ADD: mag = {{(RW-OPW){1'b0}}, a_q} + {{(RW-OPW){1'b0}}, b_q};
            OP_SUB: begin
                if (a_q < b_q) begin
                    mag     = {{(RW-OPW){1'b0}}, b_q} - {{(RW-OPW){1'b0}}, a_q};
                    mag_neg = 1'b1;
                end else begin
                    mag = {{(RW-OPW){1'b0}}, a_q} - {{(RW-OPW){1'b0}}, b_q};
                end
            end
`ifdef CALC_MUL_EN
            OP_MUL: begin
                mag      = prod[RW-1:0];
                calc_ovf = (prod > PROD_MAX);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_OPA;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        acc_digit  = 1'b0;
        take_op    = 1'b0;
        restart    = 1'b0;
        clear_all  = 1'b0;
        conv_start = 1'b0;
        if (k_esc) begin
            clear_all = 1'b1;
            state_d   = ST_OPA;
        end else begin
            case (state_q)
                ST_OPA: begin
                    if (k_digit) acc_digit = 1'b1;
                    else if (k_op) begin
                        take_op = 1'b1;
                        state_d = ST_OPB;
                    end
                end
                ST_OPB: begin
                    if (k_digit) acc_digit = 1'b1;
                    else if (k_op && cnt_q == '0) take_op = 1'b1;
                    else if (k_enter) state_d = ST_CALC;
                end
                ST_CALC: begin
                    if (calc_ovf) state_d = ST_ERR;
                    else begin
                        conv_start = 1'b1;
                        state_d    = ST_CONV;
                    end
                end
                ST_CONV: if (conv_done) state_d = ST_SHOW;
                ST_SHOW, ST_ERR: begin
                    if (k_digit) begin
                        restart = 1'b1;
                        state_d = ST_OPA;
                    end
                end
                default: state_d = ST_OPA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear_all) begin
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            entry_q <= '0;
            sign_q  <= 1'b0;
        end else begin
            // Digits beyond DIGITS are dropped, so the operand keeps its leading digits.
            if (acc_digit && cnt_q < CW'(DIGITS)) begin
                if (state_q == ST_OPA) a_q <= a_q * OPW'(10) + {{(OPW-4){1'b0}}, dec.digit};
                else                   b_q <= b_q * OPW'(10) + {{(OPW-4){1'b0}}, dec.digit};
                entry_q <= {entry_q[EW-5:0], dec.digit};
                cnt_q   <= cnt_q + CW'(1);
            end
            if (take_op) begin
                op_q    <= k_opv;
                b_q     <= '0;
                cnt_q   <= '0;
                entry_q <= '0;
            end
            if (restart) begin
                a_q     <= {{(OPW-4){1'b0}}, dec.digit};
                b_q     <= '0;
                cnt_q   <= CW'(1);
                entry_q <= {{(EW-4){1'b0}}, dec.digit};
                sign_q  <= 1'b0;
            end
            if (state_q == ST_CALC) sign_q <= mag_neg;
        end
    end

    bin2bcd_seq #(
        .W  (RW),
        .ND (DIGITS + 1)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .abort (clear_all),
        .bin   (mag),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        bcd_out      = '0;
        sign         = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        overflow     = 1'b0;
        case (state_q)
            ST_OPA, ST_OPB: bcd_out = {{(BW-EW){1'b0}}, entry_q};
            ST_CALC, ST_CONV: busy = 1'b1;
            ST_SHOW: begin
                bcd_out      = conv_bcd;
                sign         = sign_q;
                result_valid = 1'b1;
            end
            ST_ERR: begin
                bcd_out = '1;
`ifdef CALC_MUL_EN
                overflow = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_seq_engine.sv
// Directed self-checking bench for calc_seq_engine (default parameters).
// Multiplier vectors run when CALC_MUL_EN is defined, the '*'-ignored vector otherwise.
module tb_calc_seq_engine;

    localparam logic [7:0] K_PLUS  = 8'h79;
    localparam logic [7:0] K_MINUS = 8'h7B;
    localparam logic [7:0] K_MUL   = 8'h7C;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_ESC   = 8'h76;

    logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [19:0] bcd_out;
    logic        sign, busy, result_valid, overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    calc_seq_engine dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .bcd_out      (bcd_out),
        .sign         (sign),
        .busy         (busy),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [7:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic press_digit(input int d);
        press(dig_sc[d]);
    endtask

    // Press Enter in OPB and wait for the result; result_valid must first
    // appear in the 19th cycle counting the Enter cycle as 0.
    task automatic run_calc(input string tag, input logic [19:0] exp_bcd, input logic exp_sign);
        int lat;
        logic [19:0] e;
        exp_q.push_back(exp_bcd);
        press(K_ENTER);
        lat = 1;
        while (!result_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 19);
        e = exp_q.pop_front();
        check({tag, "_bcd"}, bcd_out, e);
        check({tag, "_sign"}, sign, exp_sign);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic count_results(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (result_valid || busy) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_bcd", bcd_out, 20'h0);
        check("reset_flags", {sign, busy, result_valid, overflow}, 4'b0000);
        reset = 1'b1;

        // 12 + 34
        press_digit(1); check("entry_a1", bcd_out, 20'h00001);
        press_digit(2); check("entry_a12", bcd_out, 20'h00012);
        press(K_PLUS);  check("entry_opb_zero", bcd_out, 20'h00000);
        press_digit(3); check("entry_b3", bcd_out, 20'h00003);
        press_digit(4); check("entry_b34", bcd_out, 20'h00034);
        run_calc("add_12_34", 20'h00046, 1'b0);

        // 5 - 9 straight from SHOW: the digit restarts A
        press_digit(5);
        check("show_restart_bcd", bcd_out, 20'h00005);
        check("show_restart_sign", sign, 1'b0);
        press(K_MINUS); press_digit(9);
        run_calc("sub_5_9", 20'h00004, 1'b1);

        // 9999 + 9999
        for (int i = 0; i < 4; i++) press_digit(9);
        press(K_PLUS);
        for (int i = 0; i < 4; i++) press_digit(9);
        run_calc("add_max", 20'h19998, 1'b0);

        // fifth digit dropped
        press(K_ESC);
        for (int i = 1; i <= 5; i++) press_digit(i);
        check("fifth_digit_ignored", bcd_out, 20'h01234);
        press(K_PLUS); press_digit(1);
        run_calc("add_1234_1", 20'h01235, 1'b0);

        // operator replaced before any B digit
        press(K_ESC);
        press(K_PLUS); press(K_MINUS); press_digit(7);
        run_calc("op_replace", 20'h00007, 1'b1);

        // Esc in the middle of conversion
        press(K_ESC);
        press_digit(1); press(K_PLUS); press_digit(2); press(K_ENTER);
        repeat (5) @(negedge clk);
        check("conv_busy", busy, 1'b1);
        press(K_ESC);
        check("esc_busy", busy, 1'b0);
        check("esc_bcd", bcd_out, 20'h0);
        check("esc_rv", result_valid, 1'b0);
        count_results("esc_no_result", 30);
        press_digit(6);
        check("esc_then_digit", bcd_out, 20'h00006);

        // reset low in the middle of conversion, with a coincident digit
        press(K_ESC);
        press_digit(1); press(K_PLUS); press_digit(2); press(K_ENTER);
        repeat (5) @(negedge clk);
        @(negedge clk);
        reset = 1'b0; key_valid = 1'b1; key_code = dig_sc[7];
        @(negedge clk);
        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        check("rst_busy", busy, 1'b0);
        check("rst_bcd", bcd_out, 20'h0);
        count_results("rst_no_result", 30);

        // reset wins over a digit typed in OPA
        press_digit(1);
        @(negedge clk);
        reset = 1'b0; key_valid = 1'b1; key_code = dig_sc[7];
        @(negedge clk);
        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        check("rst_precedence", bcd_out, 20'h0);

`ifdef CALC_MUL_EN
        for (int i = 0; i < 4; i++) press_digit(9);
        press(K_MUL); press_digit(9); press_digit(9);
        press(K_ENTER);
        check("mul_calc_no_ovf_yet", overflow, 1'b0);
        @(negedge clk);
        check("mul_ovf", overflow, 1'b1);
        check("mul_ovf_blank", bcd_out, 20'hFFFFF);
        press_digit(3);
        check("err_restart_bcd", bcd_out, 20'h00003);
        check("err_restart_ovf", overflow, 1'b0);
        press(K_ESC);
        press_digit(1); press_digit(2); press(K_MUL); press_digit(1); press_digit(2);
        run_calc("mul_12_12", 20'h00144, 1'b0);
`else
        press(K_ESC);
        press_digit(2); press(K_MUL);
        check("mul_ignored_bcd", bcd_out, 20'h00002);
        press_digit(3);
        check("mul_ignored_a23", bcd_out, 20'h00023);
        press(K_ENTER);
        count_results("enter_in_opa_ignored", 30);
        check("enter_in_opa_bcd", bcd_out, 20'h00023);
        check("ovf_tied", overflow, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
